// File: rtl/ps2_pkg.sv
// Shared types, constants and the set-2 scan code to ASCII table for the
// PS/2 keyboard input stage.
package ps2_pkg;

  // Decode FSM states: plain, after F0, after E0, after E0 F0.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } decode_state_t;

  // One queued keystroke.
  typedef struct packed {
    logic [7:0] ascii;
    logic [7:0] scan;
  } key_entry_t;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] ASCII_NONE = 8'h00;

  // Set-2 make code to uppercase ASCII; keys the game ignores map to ASCII_NONE.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] scan_code);
    logic [7:0] result;
    result = ASCII_NONE;
    case (scan_code)
      8'h1C: result = 8'h41; // A
      8'h32: result = 8'h42; // B
      8'h21: result = 8'h43; // C
      8'h23: result = 8'h44; // D
      8'h24: result = 8'h45; // E
      8'h2B: result = 8'h46; // F
      8'h34: result = 8'h47; // G
      8'h33: result = 8'h48; // H
      8'h43: result = 8'h49; // I
      8'h3B: result = 8'h4A; // J
      8'h42: result = 8'h4B; // K
      8'h4B: result = 8'h4C; // L
      8'h3A: result = 8'h4D; // M
      8'h31: result = 8'h4E; // N
      8'h44: result = 8'h4F; // O
      8'h4D: result = 8'h50; // P
      8'h15: result = 8'h51; // Q
      8'h2D: result = 8'h52; // R
      8'h1B: result = 8'h53; // S
      8'h2C: result = 8'h54; // T
      8'h3C: result = 8'h55; // U
      8'h2A: result = 8'h56; // V
      8'h1D: result = 8'h57; // W
      8'h22: result = 8'h58; // X
      8'h35: result = 8'h59; // Y
      8'h1A: result = 8'h5A; // Z
      8'h45: result = 8'h30; // 0
      8'h16: result = 8'h31; // 1
      8'h1E: result = 8'h32; // 2
      8'h26: result = 8'h33; // 3
      8'h25: result = 8'h34; // 4
      8'h2E: result = 8'h35; // 5
      8'h36: result = 8'h36; // 6
      8'h3D: result = 8'h37; // 7
      8'h3E: result = 8'h38; // 8
      8'h46: result = 8'h39; // 9
      8'h29: result = 8'h20; // space
      8'h5A: result = 8'h0D; // enter
      8'h66: result = 8'h08; // backspace
      default: result = ASCII_NONE;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the keyboard pins, finds falling edges of
// the PS/2 clock, assembles 11-bit frames and validates start/stop/parity.
// A frame that stalls mid-way is dropped after TIMEOUT_CYCLES idle clocks.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_strobe,
  output logic [7:0] code,
  output logic       frame_err
);

  localparam int         IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] LAST_BIT = 4'd10;

  logic              ps2_clk_meta_reg;
  logic              ps2_clk_sync_reg;
  logic              ps2_clk_prev_reg;
  logic              ps2_data_meta_reg;
  logic              ps2_data_sync_reg;
  logic              ps2_fall;

  logic [9:0]        shift_reg;
  logic [10:0]       frame_full;
  logic [3:0]        bit_cnt_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              frame_ok;
  logic              timeout_hit;

  logic              code_strobe_reg;
  logic [7:0]        code_reg;
  logic              frame_err_reg;

  // Two-flop synchronizers plus one history flop on the clock; lines idle high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_meta_reg  <= 1'b1;
      ps2_clk_sync_reg  <= 1'b1;
      ps2_clk_prev_reg  <= 1'b1;
      ps2_data_meta_reg <= 1'b1;
      ps2_data_sync_reg <= 1'b1;
    end else begin
      ps2_clk_meta_reg  <= ps2_clk;
      ps2_clk_sync_reg  <= ps2_clk_meta_reg;
      ps2_clk_prev_reg  <= ps2_clk_sync_reg;
      ps2_data_meta_reg <= ps2_data;
      ps2_data_sync_reg <= ps2_data_meta_reg;
    end
  end

  assign ps2_fall = ps2_clk_prev_reg & ~ps2_clk_sync_reg;

  // The bit arriving now completes the frame: bit k of frame_full is the k-th
  // bit on the wire (start, 8 data LSB first, parity, stop).
  assign frame_full = {ps2_data_sync_reg, shift_reg};

  // Odd parity: data bits plus the parity bit must contain an odd count of ones.
  assign frame_ok = ~frame_full[0] & frame_full[10] & (^frame_full[9:1]);

  assign timeout_hit = (bit_cnt_reg != 4'd0) &&
                       (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES));

  // Shift in bits on each falling edge, judge the frame on the 11th bit and
  // abandon a partial frame when the keyboard goes quiet for too long.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      code_strobe_reg <= 1'b0;
      code_reg        <= '0;
      frame_err_reg   <= 1'b0;
    end else begin
      code_strobe_reg <= 1'b0;
      frame_err_reg   <= 1'b0;
      if (ps2_fall) begin
        idle_cnt_reg <= '0;
        shift_reg    <= frame_full[10:1];
        if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_reg <= '0;
          if (frame_ok) begin
            code_strobe_reg <= 1'b1;
            code_reg        <= frame_full[8:1];
          end else begin
            frame_err_reg <= 1'b1;
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else if (timeout_hit) begin
        bit_cnt_reg   <= '0;
        idle_cnt_reg  <= '0;
        frame_err_reg <= 1'b1;
      end else if (bit_cnt_reg != 4'd0) begin
        idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
      end else begin
        idle_cnt_reg <= '0;
      end
    end
  end

  assign code_strobe = code_strobe_reg;
  assign code        = code_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// Keyboard input stage of the typing game: turns validated PS/2 codes into
// uppercase ASCII keystrokes, filters break sequences, extended keys and
// typematic repeats, and queues results in a show-ahead FIFO.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic       valid,
  output logic [7:0] ascii,
  output logic [7:0] scan,
  output logic       frame_err,
  output logic       overflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic          code_strobe;
  logic [7:0]    code;
  logic [7:0]    code_ascii;

  decode_state_t state_reg;
  logic [7:0]    held_reg;
  logic          push_reg;
  key_entry_t    push_entry_reg;

  key_entry_t    mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          overflow_reg;
  key_entry_t    head_entry;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_strobe(code_strobe),
    .code       (code),
    .frame_err  (frame_err)
  );

  assign code_ascii = scan_to_ascii(code);

  // Decode FSM: tracks E0/F0 prefixes and the currently held key, and stages
  // one FIFO push per new mapped make code.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= ST_IDLE;
      held_reg       <= ASCII_NONE;
      push_reg       <= 1'b0;
      push_entry_reg <= '0;
    end else begin
      push_reg <= 1'b0;
      if (code_strobe) begin
        case (state_reg)
          ST_IDLE: begin
            if (code == PS2_EXT) begin
              state_reg <= ST_EXT;
            end else if (code == PS2_BREAK) begin
              state_reg <= ST_BRK;
            end else if (code != held_reg) begin
              // A code equal to held is a typematic repeat and is dropped.
              held_reg <= code;
              if (code_ascii != ASCII_NONE) begin
                push_reg             <= 1'b1;
                push_entry_reg.ascii <= code_ascii;
                push_entry_reg.scan  <= code;
              end
            end
          end
          ST_BRK: begin
            // Releasing the held key re-arms it so the next press is accepted.
            if (code == held_reg) begin
              held_reg <= ASCII_NONE;
            end
            state_reg <= ST_IDLE;
          end
          ST_EXT: begin
            if (code == PS2_BREAK) begin
              state_reg <= ST_EXT_BRK;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                      (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
  assign do_pop     = rd_en && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_push    = push_reg && (!fifo_full || do_pop);

  // FIFO storage, pointers and the sticky overflow flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg[ADDR_W-1:0]] <= push_entry_reg;
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push_reg && fifo_full && !do_pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Show-ahead head: the oldest entry is visible without a read request.
  assign head_entry = mem_reg[rd_ptr_reg[ADDR_W-1:0]];
  assign valid      = !fifo_empty;
  assign ascii      = head_entry.ascii;
  assign scan       = head_entry.scan;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed testbench for ps2_key_decoder with a keystroke scoreboard.
module tb_ps2_key_decoder;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 10;

  logic       clk;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       rd_en;
  logic       valid;
  logic [7:0] ascii;
  logic [7:0] scan;
  logic       frame_err;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;

  logic [15:0] sb_q [$];
  logic        vhist [1:HALF];
  logic        ehist [1:HALF];

  ps2_key_decoder #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .valid    (valid),
    .ascii    (ascii),
    .scan     (scan),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0; rd_en = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("rst_valid", valid, 1'b0);
    check_byte("rst_ascii", ascii, 8'h00);
    check_byte("rst_scan", scan, 8'h00);
    check_bit("rst_frame_err", frame_err, 1'b0);
    check_bit("rst_overflow", overflow, 1'b0);
    clrn = 1'b1;
    @(negedge clk);
    sb_q.delete();
  endtask

  // Compare the head against the scoreboard front (used on the write cycle pop).
  task automatic compare_head(input string tag);
    logic [15:0] e;
    check_bit({tag, "_valid"}, valid, 1'b1);
    check_int({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 1 : 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_byte({tag, "_ascii"}, ascii, e[15:8]);
      check_byte({tag, "_scan"}, scan, e[7:0]);
    end
  endtask

  // Bit-bang nbits of a frame; after the 11th falling edge record valid and
  // frame_err for HALF cycles. Optionally pop on the keystroke's write cycle.
  task automatic send_frame(input logic [7:0] code, input bit bad_parity,
                            input int nbits, input bit pop_at_write);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      ps2_data = f[b];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (b == 10) begin
        for (int k = 1; k <= HALF; k++) begin
          @(negedge clk);
          vhist[k] = valid;
          ehist[k] = frame_err;
          if (pop_at_write && k == 4) begin
            compare_head("pop_on_write");
            rd_en = 1'b1;
          end
          if (pop_at_write && k == 5) rd_en = 1'b0;
        end
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] code, input logic [7:0] exp_ascii, input bit exp_push);
    if (exp_push) sb_q.push_back({exp_ascii, code});
    send_frame(code, 1'b0, 11, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    compare_head(tag);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    check_bit({tag, "_valid_low"}, valid, 1'b0);
    check_int({tag, "_sb_left"}, sb_q.size(), 0);
  endtask

  logic [7:0] keys   [9];
  logic [7:0] keys_a [9];
  int         ferr_base;

  initial begin
    keys   = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    keys_a = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;

    // Single key: latency, mapping, pop.
    do_reset();
    ferr_base = ferr_cnt;
    send_key(8'h1C, 8'h41, 1'b1);
    check_bit("lat_valid_t2", vhist[4], 1'b0);
    check_bit("lat_valid_t3", vhist[5], 1'b1);
    check_bit("lat_no_ferr", ehist[3], 1'b0);
    pop_check("key_A");
    expect_empty("key_A");
    check_int("key_A_ferr", ferr_cnt - ferr_base, 0);

    // Typematic repeats and release/re-press.
    do_reset();
    send_key(8'h1C, 8'h41, 1'b1);
    send_key(8'h1C, 8'h41, 1'b0);
    send_key(8'h1C, 8'h41, 1'b0);
    send_key(8'hF0, 8'h00, 1'b0);
    send_key(8'h1C, 8'h41, 1'b1);
    send_key(8'h1C, 8'h41, 1'b0);
    pop_check("repeat_1");
    pop_check("repeat_2");
    expect_empty("repeat");

    // Parity error then a good frame.
    do_reset();
    ferr_base = ferr_cnt;
    send_frame(8'h16, 1'b1, 11, 1'b0);
    check_bit("perr_pre", ehist[2], 1'b0);
    check_bit("perr_pulse", ehist[3], 1'b1);
    check_bit("perr_post", ehist[4], 1'b0);
    check_bit("perr_no_valid", vhist[5], 1'b0);
    check_int("perr_count", ferr_cnt - ferr_base, 1);
    send_key(8'h45, 8'h30, 1'b1);
    pop_check("digit_0");
    expect_empty("perr");

    // Extended make and break are swallowed.
    do_reset();
    ferr_base = ferr_cnt;
    send_key(8'hE0, 8'h00, 1'b0);
    send_key(8'h75, 8'h00, 1'b0);
    send_key(8'hE0, 8'h00, 1'b0);
    send_key(8'hF0, 8'h00, 1'b0);
    send_key(8'h75, 8'h00, 1'b0);
    @(negedge clk);
    check_bit("ext_no_entry", valid, 1'b0);
    check_int("ext_no_ferr", ferr_cnt - ferr_base, 0);
    send_key(8'h29, 8'h20, 1'b1);
    pop_check("space");
    expect_empty("ext");

    // Nine keys without popping: ninth is lost, overflow sticks.
    do_reset();
    for (int i = 0; i < 9; i++) send_key(keys[i], keys_a[i], (i < DEPTH) ? 1'b1 : 1'b0);
    check_bit("ovf_set", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
    expect_empty("ovf");
    check_bit("ovf_sticky", overflow, 1'b1);

    // Nine keys with a pop on the ninth key's write cycle: nothing lost.
    do_reset();
    for (int i = 0; i < 8; i++) send_key(keys[i], keys_a[i], 1'b1);
    sb_q.push_back({keys_a[8], keys[8]});
    send_frame(keys[8], 1'b0, 11, 1'b1);
    check_bit("full_pop_no_ovf", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) pop_check("full_pop_drain");
    expect_empty("full_pop");

    // Partial frame then idle: timeout abort, then a good frame.
    do_reset();
    ferr_base = ferr_cnt;
    send_frame(8'h5A, 1'b0, 5, 1'b0);
    repeat (TIMEOUT + TIMEOUT / 5) @(negedge clk);
    check_int("timeout_ferr", ferr_cnt - ferr_base, 1);
    check_bit("timeout_no_valid", valid, 1'b0);
    send_key(8'h5A, 8'h0D, 1'b1);
    pop_check("enter");
    expect_empty("timeout");
    check_int("timeout_ferr_total", ferr_cnt - ferr_base, 1);

    // Reset mid-frame: silent abort, next frame decodes cleanly.
    do_reset();
    send_frame(8'h66, 1'b0, 4, 1'b0);
    ferr_base = ferr_cnt;
    do_reset();
    send_key(8'h66, 8'h08, 1'b1);
    pop_check("backspace");
    expect_empty("mid_reset");
    check_int("mid_reset_ferr", ferr_cnt - ferr_base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Keyboard input stage of the typing game. Receives raw PS/2 frames from the on-board keyboard, validates them, and turns make codes into uppercase ASCII. Typematic repeats and break codes are filtered out, and results are queued in a small show-ahead FIFO. The game core pops one keystroke at a time and compares it with the falling characters held in the ASCII display RAM.

## Interface
Parameters:
- FIFO_DEPTH, 8: keystroke queue entries; power of two, at least 2.
- TIMEOUT_CYCLES, 50000: idle clk cycles (1 ms at 50 MHz) after which a partial frame is discarded.

Ports:
- clk  in  1  system clock, CLOCK_50; every register in this block runs on it.
- clrn  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin; asynchronous to clk; input only.
- ps2_data  in  1  raw PS/2 data pin; asynchronous to clk; input only.
- rd_en  in  1  pop request for the FIFO head.
- valid  out  1  FIFO is non-empty; ascii and scan show the head entry.
- ascii  out  8  uppercase ASCII code of the head entry.
- scan  out  8  set-2 make code of the head entry.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- overflow  out  1  sticky flag: a keystroke was dropped because the FIFO was full; cleared only by reset.

## Operation
- **Synchronizer.** ps2_clk and ps2_data each pass through a 2-flop synchronizer. A third flop on the synchronized clock forms the falling-edge detector; a falling edge is `prev==1 && cur==0`.
- **Frame receive (sub-module).** On each falling edge, sample ps2_data into an 11-bit frame: start bit, 8 data bits LSB-first, parity bit, stop bit.
- **Frame check** after the 11th bit: start==0, stop==1, and odd parity over data plus parity bit.
  - Frame passes: emit code_strobe with the 8-bit code.
  - Frame fails: pulse frame_err and emit nothing.
- **Timeout.** An idle counter resets on every falling edge. If it reaches TIMEOUT_CYCLES while the bit count is nonzero:
  - bit count clears to 0;
  - frame_err pulses once;
  - the partial frame is discarded.
- **Decode FSM.** States: IDLE, BRK, EXT, EXT_BRK. Transitions on code_strobe:
  - IDLE: E0 goes to EXT; F0 goes to BRK; any other code is treated as a make code and stays in IDLE.
  - BRK: clears held if code==held, then returns to IDLE.
  - EXT: F0 goes to EXT_BRK; any other code is discarded and goes to IDLE.
  - EXT_BRK: discards the code, goes to IDLE.
- **Make handling.**
  - If code==held: it is a typematic repeat; drop it.
  - Otherwise: set held=code. If the code maps to ASCII, push {ascii, code} into the FIFO.
- **Mapping.** Combinational function; unmapped codes give ascii 0x00 and are not pushed.
  - A–Z: 0x41–0x5A.
  - 0–9: 0x30–0x39.
  - Space 29→0x20, Enter 5A→0x0D, Backspace 66→0x08.
- **FIFO.** Show-ahead; pointers are log2(FIFO_DEPTH)+1 bits wide, and full/empty are derived from the MSB comparison.
  - Pop (rd_en && valid) advances the head.
  - rd_en while empty is ignored.
  - Push while full with no pop in the same cycle: entry dropped, overflow set.
  - Push and pop in the same cycle when full: both happen; no overflow.
  - Push and pop in the same cycle when empty: the push happens; the pop is ignored.

## Timing
- Reset values: valid=0, ascii=0x00, scan=0x00, frame_err=0, overflow=0. Reset also clears:
  - FSM to IDLE and held=0x00;
  - FIFO pointers;
  - bit count and idle counter;
  - synchronizer flops, set to 1 (idle line).
- Edge-detect latency: 3 clk cycles from a ps2_clk pin fall to the detected edge.
- Frame latency:
  - cycle T: 11th edge detected;
  - T+1: code_strobe, or frame_err;
  - T+2: FSM updates and the FIFO write happens;
  - T+3: valid=1, with ascii and scan stable.
- Pop: rd_en sampled at cycle N, next entry or valid=0 at N+1.
- frame_err is exactly one cycle wide per rejected or aborted frame.
- Reset asserted mid-frame aborts the frame silently (no frame_err). Reset mid-sequence (after E0 or F0) returns the FSM to IDLE.

## Structure
- Package ps2_pkg holds:
  - the decode-state enum;
  - constants: PS2_BREAK=8'hF0, PS2_EXT=8'hE0, ASCII_NONE=8'h00;
  - the scan-to-ASCII function.
- Sub-module ps2_frame_rx covers synchronizer, edge detect, shift register, frame check and timeout. Its outputs are code_strobe, code[7:0] and frame_err.
- The top of this block holds the decode FSM, held register, mapping and FIFO.

## Test plan
- Frame 1C → valid=1 at T+3, ascii=0x41, scan=0x1C; rd_en for one cycle → valid=0.
- Frames 1C, 1C, 1C, F0, 1C, 1C → exactly two entries, both 0x41 (the repeats are dropped; the key is pressed again after release).
- Frame 16 with the parity bit flipped → one-cycle frame_err, valid stays 0; then frame 45 → ascii=0x30.
- E0 75, then E0 F0 75 (arrow key) → no entries, no frame_err; then frame 29 → ascii=0x20.
- Nine distinct mapped keys, no rd_en → 8 entries, overflow=1, 9th key lost. On the 9th key's write cycle with rd_en=1 instead → no overflow, 8 entries.
- 5 bits of a frame, then 1.2 ms idle → one frame_err; then a full frame 5A → ascii=0x0D.
